// File: rtl/axis_shift_pkg.sv
// Shared types and helpers for the stream shift / unshift blocks.
// Keep helpers operate on MAX_KEEP-wide vectors; callers size-cast to their own width.
package axis_shift_pkg;

   localparam int unsigned MAX_KEEP = 64;

   typedef enum logic [1:0] {
      StIdle,
      StHold,
      StFlush
   } state_e;

   function automatic int unsigned keep_width(input int unsigned bus_width);
      return bus_width / 8;
   endfunction

   function automatic logic [7:0] popcount_keep(input logic [MAX_KEEP-1:0] keep);
      logic [7:0] cnt;
      cnt = '0;
      for (int unsigned i = 0; i < MAX_KEEP; i++) begin
         cnt = cnt + {7'd0, keep[i]};
      end
      return cnt;
   endfunction

   function automatic logic [MAX_KEEP-1:0] keep_mask(input int unsigned n);
      logic [MAX_KEEP-1:0] m;
      for (int unsigned i = 0; i < MAX_KEEP; i++) begin
         m[i] = (i < n);
      end
      return m;
   endfunction

endpackage

// File: rtl/axis_keep_count.sv
// Combinational popcount of a TKEEP vector.
module axis_keep_count
   import axis_shift_pkg::*;
#(
   parameter int unsigned KEEP_WIDTH = 64,
   localparam int unsigned CountWidth = $clog2(KEEP_WIDTH + 1)
) (
   input  logic [KEEP_WIDTH-1:0] keep_i,
   output logic [CountWidth-1:0] count_o
);

   always_comb begin
      count_o = CountWidth'(popcount_keep(MAX_KEEP'(keep_i)));
   end

endmodule

// File: rtl/axis_unshift.sv
// AXI4-Stream byte un-shifter: drops SHIFT_BYTES leading bytes per packet and repacks to lane 0.
// Optional header capture ports are built when AXIS_UNSHIFT_HDR_EN is defined.
module axis_unshift
   import axis_shift_pkg::*;
#(
   parameter int unsigned BUS_WIDTH   = 512,
   parameter int unsigned SHIFT_BYTES = 2,
   parameter int unsigned KEEP_WIDTH  = keep_width(BUS_WIDTH)
) (
   input  logic                  aclk,
   input  logic                  ARESET,
   input  logic [BUS_WIDTH-1:0]  in_tdata,
   input  logic [KEEP_WIDTH-1:0] in_tkeep,
   input  logic                  in_tvalid,
   input  logic                  in_tlast,
   output logic                  in_tready,
   output logic [BUS_WIDTH-1:0]  out_tdata,
   output logic [KEEP_WIDTH-1:0] out_tkeep,
   output logic                  out_tvalid,
   output logic                  out_tlast,
   input  logic                  out_tready,
   output logic                  runt_err,
   output logic                  busy
`ifdef AXIS_UNSHIFT_HDR_EN
   ,
   output logic [8*SHIFT_BYTES-1:0] hdr_data,
   output logic                     hdr_valid
`endif
);

   localparam int unsigned CountWidth = $clog2(KEEP_WIDTH + 1);

   function automatic logic [BUS_WIDTH-1:0] byte_mask(input logic [KEEP_WIDTH-1:0] k);
      logic [BUS_WIDTH-1:0] m;
      for (int unsigned i = 0; i < KEEP_WIDTH; i++) begin
         m[8*i +: 8] = {8{k[i]}};
      end
      return m;
   endfunction

   state_e                state_q, state_d;
   logic [BUS_WIDTH-1:0]  hold_q, hold_d;
   logic [KEEP_WIDTH-1:0] flush_keep_q, flush_keep_d;
   logic [BUS_WIDTH-1:0]  out_tdata_q, out_tdata_d;
   logic [KEEP_WIDTH-1:0] out_tkeep_q, out_tkeep_d;
   logic                  out_tvalid_q, out_tvalid_d;
   logic                  out_tlast_q, out_tlast_d;
   logic                  runt_q, runt_d;

   logic [CountWidth-1:0] k_cnt;
   int unsigned           k_int;
   logic                  out_free;
   logic                  accept;
   logic                  is_runt_len;
   logic [KEEP_WIDTH-1:0] keep_tail;
   logic [KEEP_WIDTH-1:0] keep_end;
   logic [BUS_WIDTH-1:0]  in_shift;
   logic [BUS_WIDTH-1:0]  cat_data;

   axis_keep_count #(
      .KEEP_WIDTH(KEEP_WIDTH)
   ) u_keep_count (
      .keep_i (in_tkeep),
      .count_o(k_cnt)
   );

   assign k_int       = 32'(k_cnt);
   assign is_runt_len = (k_int <= SHIFT_BYTES);
   assign out_free    = !out_tvalid_q || out_tready;
   assign in_tready   = out_free && (state_q != StFlush);
   assign accept      = in_tvalid && in_tready;

   // keep_tail: bytes past the header on a last beat; keep_end: hold bytes plus a short last beat.
   assign keep_tail = KEEP_WIDTH'(keep_mask(k_int - SHIFT_BYTES));
   assign keep_end  = KEEP_WIDTH'(keep_mask(KEEP_WIDTH - SHIFT_BYTES + k_int));
   assign in_shift  = in_tdata >> (8 * SHIFT_BYTES);
   assign cat_data  = hold_q | (in_tdata << (8 * (KEEP_WIDTH - SHIFT_BYTES)));

   always_comb begin
      state_d      = state_q;
      hold_d       = hold_q;
      flush_keep_d = flush_keep_q;
      out_tdata_d  = out_tdata_q;
      out_tkeep_d  = out_tkeep_q;
      out_tvalid_d = out_tvalid_q;
      out_tlast_d  = out_tlast_q;
      runt_d       = 1'b0;

      if (out_tvalid_q && out_tready) begin
         out_tvalid_d = 1'b0;
      end

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (!in_tlast) begin
                  hold_d  = in_shift;
                  state_d = StHold;
               end else if (!is_runt_len) begin
                  out_tdata_d  = in_shift & byte_mask(keep_tail);
                  out_tkeep_d  = keep_tail;
                  out_tvalid_d = 1'b1;
                  out_tlast_d  = 1'b1;
               end else begin
                  runt_d = 1'b1;
               end
            end
         end
         StHold: begin
            if (accept) begin
               out_tvalid_d = 1'b1;
               if (!in_tlast) begin
                  out_tdata_d = cat_data;
                  out_tkeep_d = '1;
                  out_tlast_d = 1'b0;
                  hold_d      = in_shift;
               end else if (is_runt_len) begin
                  out_tdata_d = cat_data & byte_mask(keep_end);
                  out_tkeep_d = keep_end;
                  out_tlast_d = 1'b1;
                  state_d     = StIdle;
               end else begin
                  out_tdata_d  = cat_data;
                  out_tkeep_d  = '1;
                  out_tlast_d  = 1'b0;
                  hold_d       = in_shift & byte_mask(keep_tail);
                  flush_keep_d = keep_tail;
                  state_d      = StFlush;
               end
            end
         end
         StFlush: begin
            if (out_free) begin
               out_tdata_d  = hold_q;
               out_tkeep_d  = flush_keep_q;
               out_tvalid_d = 1'b1;
               out_tlast_d  = 1'b1;
               state_d      = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge aclk or posedge ARESET) begin
      if (ARESET) begin
         state_q      <= StIdle;
         hold_q       <= '0;
         flush_keep_q <= '0;
         out_tdata_q  <= '0;
         out_tkeep_q  <= '0;
         out_tvalid_q <= 1'b0;
         out_tlast_q  <= 1'b0;
         runt_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_q       <= hold_d;
         flush_keep_q <= flush_keep_d;
         out_tdata_q  <= out_tdata_d;
         out_tkeep_q  <= out_tkeep_d;
         out_tvalid_q <= out_tvalid_d;
         out_tlast_q  <= out_tlast_d;
         runt_q       <= runt_d;
      end
   end

   assign out_tdata  = out_tdata_q;
   assign out_tkeep  = out_tkeep_q;
   assign out_tvalid = out_tvalid_q;
   assign out_tlast  = out_tlast_q;
   assign runt_err   = runt_q;
   assign busy       = (state_q != StIdle);

`ifdef AXIS_UNSHIFT_HDR_EN
   logic [8*SHIFT_BYTES-1:0] hdr_data_q, hdr_data_d;
   logic                     hdr_valid_q, hdr_valid_d;

   // Header bytes missing from a short runt latch as zero.
   always_comb begin
      hdr_data_d  = hdr_data_q;
      hdr_valid_d = 1'b0;
      if (accept && (state_q == StIdle)) begin
         hdr_valid_d = 1'b1;
         for (int unsigned i = 0; i < SHIFT_BYTES; i++) begin
            hdr_data_d[8*i +: 8] = in_tkeep[i] ? in_tdata[8*i +: 8] : 8'h00;
         end
      end
   end

   always_ff @(posedge aclk or posedge ARESET) begin
      if (ARESET) begin
         hdr_data_q  <= '0;
         hdr_valid_q <= 1'b0;
      end else begin
         hdr_data_q  <= hdr_data_d;
         hdr_valid_q <= hdr_valid_d;
      end
   end

   assign hdr_data  = hdr_data_q;
   assign hdr_valid = hdr_valid_q;
`endif

endmodule

// File: tb/tb_axis_unshift.sv
// Self-checking bench for axis_unshift (BUS_WIDTH=32, SHIFT_BYTES=2), byte-stream scoreboard.
module tb_axis_unshift;

   localparam int unsigned BW = 32;
   localparam int unsigned S  = 2;
   localparam int unsigned N  = BW / 8;

   logic          aclk = 1'b0;
   logic          ARESET;
   logic [BW-1:0] in_tdata;
   logic [N-1:0]  in_tkeep;
   logic          in_tvalid;
   logic          in_tlast;
   logic          in_tready;
   logic [BW-1:0] out_tdata;
   logic [N-1:0]  out_tkeep;
   logic          out_tvalid;
   logic          out_tlast;
   logic          out_tready;
   logic          runt_err;
   logic          busy;
`ifdef AXIS_UNSHIFT_HDR_EN
   logic [8*S-1:0] hdr_data;
   logic           hdr_valid;
`endif

   axis_unshift #(
      .BUS_WIDTH  (BW),
      .SHIFT_BYTES(S)
   ) dut (
      .aclk      (aclk),
      .ARESET    (ARESET),
      .in_tdata  (in_tdata),
      .in_tkeep  (in_tkeep),
      .in_tvalid (in_tvalid),
      .in_tlast  (in_tlast),
      .in_tready (in_tready),
      .out_tdata (out_tdata),
      .out_tkeep (out_tkeep),
      .out_tvalid(out_tvalid),
      .out_tlast (out_tlast),
      .out_tready(out_tready),
      .runt_err  (runt_err),
      .busy      (busy)
`ifdef AXIS_UNSHIFT_HDR_EN
      ,
      .hdr_data  (hdr_data),
      .hdr_valid (hdr_valid)
`endif
   );

   always #5 aclk = ~aclk;

   typedef struct packed {
      logic [7:0] d;
      logic       last;
   } sb_t;

   sb_t sb_q[$];
   int  errors    = 0;
   int  checks    = 0;
   int  out_beats = 0;
   int  runt_seen = 0;
   int  exp_runts = 0;
   bit  rand_rdy  = 1'b0;

   // Output ready: always 1 in directed tests, 50% random in the random test.
   initial begin
      out_tready = 1'b1;
      forever begin
         @(posedge aclk);
         #1;
         out_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Output monitor: stall stability, lane hygiene and byte-stream scoreboard.
   initial begin
      bit                     stall_pend;
      logic [BW+N+1:0]        saved;
      logic [BW-1:0]          bm;
      int                     top;
      sb_t                    e;
      stall_pend = 1'b0;
      saved      = '0;
      forever begin
         @(negedge aclk);
         if (ARESET) begin
            stall_pend = 1'b0;
         end else begin
            if (stall_pend) begin
               checks++;
               if ({out_tvalid, out_tlast, out_tkeep, out_tdata} !== saved) begin
                  errors++;
                  $display("FAIL stall_stable: got %h required %h",
                           {out_tvalid, out_tlast, out_tkeep, out_tdata}, saved);
               end
            end
            if (runt_err === 1'b1) runt_seen++;
            if (out_tvalid && out_tready) begin
               out_beats++;
               top = 0;
               for (int j = 0; j < int'(N); j++) begin
                  bm[8*j +: 8] = {8{out_tkeep[j]}};
                  if (out_tkeep[j]) top = j;
               end
               checks++;
               if (!(out_tkeep inside {4'h1, 4'h3, 4'h7, 4'hF}) || ((out_tdata & ~bm) !== '0)) begin
                  errors++;
                  $display("FAIL out_lanes: keep %h data %h, required contiguous keep and zero lanes",
                           out_tkeep, out_tdata);
               end
               for (int j = 0; j < int'(N); j++) begin
                  if (out_tkeep[j]) begin
                     checks++;
                     if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL sb_extra: got byte %h, required no output", out_tdata[8*j +: 8]);
                     end else begin
                        e = sb_q.pop_front();
                        if (out_tdata[8*j +: 8] !== e.d ||
                            (out_tlast && (j == top)) !== e.last) begin
                           errors++;
                           $display("FAIL sb_byte: got %h last %b, required %h last %b",
                                    out_tdata[8*j +: 8], out_tlast && (j == top), e.d, e.last);
                        end
                     end
                  end
               end
            end
            stall_pend = out_tvalid && !out_tready;
            saved      = {out_tvalid, out_tlast, out_tkeep, out_tdata};
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge aclk);
         #1;
      end
   endtask

   // Called at posedge+1; returns at posedge+1 right after the accepting edge.
   task automatic send_beat(input logic [BW-1:0] d, input logic [N-1:0] k, input logic l);
      int tmo;
      in_tdata  = d;
      in_tkeep  = k;
      in_tlast  = l;
      in_tvalid = 1'b1;
      tmo       = 0;
      @(negedge aclk);
      while (!in_tready && tmo < 1000) begin
         @(negedge aclk);
         tmo++;
      end
      if (tmo >= 1000) begin
         checks++;
         errors++;
         $display("FAIL in_tready_timeout: got 0, required 1 within 1000 cycles");
      end
      @(posedge aclk);
      #1;
      in_tvalid = 1'b0;
   endtask

   task automatic send_pkt(input int len, input bit rnd, input logic [7:0] base);
      logic [7:0]    b[$];
      logic [BW-1:0] d;
      logic [N-1:0]  k;
      b = {};
      for (int i = 0; i < len; i++) begin
         b.push_back(rnd ? 8'($urandom_range(0, 255)) : 8'(base + 8'(i)));
      end
      for (int i = S; i < len; i++) sb_q.push_back('{d: b[i], last: (i == len - 1)});
      if (len <= int'(S)) exp_runts++;
      for (int i = 0; i < len; i += N) begin
         d = '0;
         k = '0;
         for (int j = 0; j < int'(N); j++) begin
            if (i + j < len) begin
               d[8*j +: 8] = b[i+j];
               k[j]        = 1'b1;
            end
         end
         if (rnd && $urandom_range(0, 3) == 0) idle(1);
         send_beat(d, k, (i + int'(N) >= len));
      end
   endtask

   task automatic drain();
      int tmo;
      tmo = 0;
      while (sb_q.size() != 0 && tmo < 2000) begin
         idle(1);
         tmo++;
      end
      idle(3);
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d bytes pending, required 0", sb_q.size());
      end
   endtask

   task automatic test_reset();
      ARESET    = 1'b1;
      in_tvalid = 1'b0;
      in_tlast  = 1'b0;
      in_tdata  = '0;
      in_tkeep  = '0;
      repeat (3) @(posedge aclk);
      #1;
      checks++;
      if ({out_tvalid, out_tlast, out_tdata, out_tkeep, runt_err, busy} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %b/%b/%h/%h/%b/%b, required all 0",
                  out_tvalid, out_tlast, out_tdata, out_tkeep, runt_err, busy);
      end
`ifdef AXIS_UNSHIFT_HDR_EN
      checks++;
      if ({hdr_data, hdr_valid} !== '0) begin
         errors++;
         $display("FAIL reset_hdr: got %h/%b, required 0/0", hdr_data, hdr_valid);
      end
`endif
      @(negedge aclk);
      ARESET = 1'b0;
      idle(1);
      checks++;
      if (in_tready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: got %b, required 1", in_tready);
      end
   endtask

   task automatic test_three_beat();
      int b0;
      b0 = out_beats;
      send_pkt(12, 1'b0, 8'h00);
      checks++;
      if (in_tready !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL flush_ready: got in_tready %b busy %b, required 0 and 1", in_tready, busy);
      end
      drain();
      checks++;
      if (out_beats - b0 != 3) begin
         errors++;
         $display("FAIL three_beat_count: got %0d beats, required 3", out_beats - b0);
      end
   endtask

   task automatic test_two_beat();
      send_pkt(6, 1'b0, 8'h00);
      checks++;
      if (busy !== 1'b0 || out_tvalid !== 1'b1 || out_tkeep !== 4'hF || out_tlast !== 1'b1 ||
          out_tdata !== 32'h0504_0302) begin
         errors++;
         $display("FAIL two_beat: got busy %b valid %b keep %h last %b data %h, required 0 1 f 1 05040302",
                  busy, out_tvalid, out_tkeep, out_tlast, out_tdata);
      end
      drain();
   endtask

   task automatic test_single();
      send_pkt(4, 1'b0, 8'h00);
      checks++;
      if (out_tvalid !== 1'b1 || out_tkeep !== 4'h3 || out_tlast !== 1'b1 ||
          out_tdata !== 32'h0000_0302) begin
         errors++;
         $display("FAIL single: got valid %b keep %h last %b data %h, required 1 3 1 00000302",
                  out_tvalid, out_tkeep, out_tlast, out_tdata);
      end
      idle(1);
      checks++;
      if (runt_err !== 1'b0) begin
         errors++;
         $display("FAIL single_runt: got %b, required 0", runt_err);
      end
      drain();
   endtask

   task automatic test_runt();
      int b0;
      b0 = out_beats;
      send_pkt(2, 1'b0, 8'h00);
      checks++;
      if (runt_err !== 1'b1 || out_tvalid !== 1'b0) begin
         errors++;
         $display("FAIL runt_pulse: got runt %b valid %b, required 1 0", runt_err, out_tvalid);
      end
`ifdef AXIS_UNSHIFT_HDR_EN
      checks++;
      if (hdr_valid !== 1'b1 || hdr_data !== 16'h0100) begin
         errors++;
         $display("FAIL runt_hdr: got %b %h, required 1 0100", hdr_valid, hdr_data);
      end
`endif
      idle(1);
      checks++;
      if (runt_err !== 1'b0) begin
         errors++;
         $display("FAIL runt_width: got %b one cycle later, required 0", runt_err);
      end
      idle(3);
      checks++;
      if (out_beats != b0) begin
         errors++;
         $display("FAIL runt_output: got %0d beats, required 0", out_beats - b0);
      end
   endtask

   task automatic test_random();
      rand_rdy = 1'b1;
      for (int p = 0; p < 100; p++) send_pkt(int'($urandom_range(1, 64)), 1'b1, 8'h00);
      drain();
      rand_rdy = 1'b0;
      idle(2);
      checks++;
      if (runt_seen != exp_runts) begin
         errors++;
         $display("FAIL runt_count: got %0d, required %0d", runt_seen, exp_runts);
      end
   endtask

   task automatic test_reset_mid();
      int b0;
      send_beat(32'h0302_0100, 4'hF, 1'b0);
      send_beat(32'h0706_0504, 4'hF, 1'b0);
      checks++;
      if (busy !== 1'b1 || out_tvalid !== 1'b1) begin
         errors++;
         $display("FAIL mid_busy: got busy %b valid %b, required 1 1", busy, out_tvalid);
      end
      ARESET = 1'b1;
      #1;
      checks++;
      if ({out_tvalid, out_tlast, out_tdata, out_tkeep, runt_err, busy} !== '0) begin
         errors++;
         $display("FAIL mid_async_reset: got %b/%b/%h/%h/%b/%b, required all 0",
                  out_tvalid, out_tlast, out_tdata, out_tkeep, runt_err, busy);
      end
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      ARESET = 1'b0;
      b0 = out_beats;
      idle(4);
      checks++;
      if (out_beats != b0 || out_tvalid !== 1'b0) begin
         errors++;
         $display("FAIL mid_residue: got %0d beats valid %b, required 0 beats valid 0",
                  out_beats - b0, out_tvalid);
      end
      send_pkt(4, 1'b0, 8'h10);
      checks++;
      if (out_tvalid !== 1'b1 || out_tkeep !== 4'h3 || out_tdata !== 32'h0000_1312) begin
         errors++;
         $display("FAIL mid_next_pkt: got valid %b keep %h data %h, required 1 3 00001312",
                  out_tvalid, out_tkeep, out_tdata);
      end
      drain();
   endtask

   initial begin
      test_reset();
      test_three_beat();
      test_two_beat();
      test_single();
      test_runt();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/axis_unshift.md
Name: axis_unshift

Overview:
- AXI4-Stream byte un-shifter; the inverse of the team's stream shift block.
- Strips the SHIFT_BYTES leading bytes that the shifter inserted at the start of each packet, then re-packs the remaining payload to lane 0.
- Sits on the receive side of the datapath, one clock domain, full throughput except one flush bubble per packet.
- Non-standard side outputs report runt packets and the stripped header.

Parameters:
BUS_WIDTH, 512, TDATA width in bits; must be a multiple of 8 (512 or 256 used).
SHIFT_BYTES, 2, number of leading bytes dropped per packet; range 1 to KEEP_WIDTH-1.
KEEP_WIDTH, BUS_WIDTH/8, TKEEP width, one bit per byte.

Ports:
aclk  input  1  clock; all logic on the rising edge.
ARESET  input  1  asynchronous, active-high reset.
in_tdata  input  BUS_WIDTH  input stream data.
in_tkeep  input  KEEP_WIDTH  input byte qualifiers; contiguous from bit 0; only the tlast beat may be partial.
in_tvalid  input  1  input valid.
in_tlast  input  1  input end of packet.
in_tready  output  1  input ready.
out_tdata  output  BUS_WIDTH  realigned data.
out_tkeep  output  KEEP_WIDTH  realigned qualifiers; contiguous from bit 0.
out_tvalid  output  1  output valid.
out_tlast  output  1  output end of packet.
out_tready  input  1  output ready.
runt_err  output  1  one-cycle pulse when a packet holds at most SHIFT_BYTES bytes.
busy  output  1  high while a packet is in progress (HOLD or FLUSH).

Behaviour:
- Reset: out_tvalid, out_tlast, out_tdata, out_tkeep, runt_err and busy are all 0. State is IDLE and the hold register is cleared.
- Reset mid-packet: the partial packet is discarded. No output beat is emitted after reset deasserts until a new packet arrives.
- Output is registered. in_tready = (!out_tvalid | out_tready) & (state != FLUSH). A beat is accepted when in_tvalid & in_tready.
- N = KEEP_WIDTH, S = SHIFT_BYTES, K = popcount(in_tkeep) of the accepted beat.
- IDLE, accepted beat with !tlast: store bytes [N-1:S] in the hold register (N-S bytes). No output. Go to HOLD.
- IDLE, accepted beat with tlast and K>S: output bytes [K-1:S] at lanes 0..K-S-1, keep = K-S ones, tlast=1. Stay in IDLE.
- IDLE, accepted beat with tlast and K<=S: runt. No output; runt_err pulses the next cycle; stay in IDLE.
- HOLD, accepted beat: output = {new bytes [S-1:0], hold}.
  - If !tlast: keep all ones; reload the hold register with new bytes [N-1:S]; stay in HOLD.
  - If tlast and K<=S: keep = N-S+K ones, tlast=1; go to IDLE.
  - If tlast and K>S: full beat, tlast=0; hold = new bytes [K-1:S]; go to FLUSH.
- FLUSH: when the output register is free, emit hold with keep = K-S ones and tlast=1, then go to IDLE. in_tready is 0 throughout FLUSH.
- Latency: one cycle from the accepted input beat to out_tvalid.
- Throughput: one beat per cycle with no bubbles, except the FLUSH beat.
- Output stall: out_tvalid and all out_* fields hold stable until out_tready. No data is lost or duplicated.
- Output lanes above the keep range are driven 0.
- busy = (state != IDLE).

Optional Feature:
- Macro: AXIS_UNSHIFT_HDR_EN.
- When defined:
  - Adds output ports hdr_data [8*SHIFT_BYTES-1:0] and hdr_valid (1 bit).
  - On acceptance of each packet's first beat, including runts, hdr_data latches bytes [S-1:0] and hdr_valid pulses for one cycle.
  - For a runt with K<S, the missing header bytes latch as 0.
  - hdr_data and hdr_valid reset to 0.
- When undefined: neither port exists and no header register is built.

Decomposition:
- Package axis_shift_pkg holds:
  - KEEP_WIDTH derivation.
  - State typedef: IDLE, HOLD, FLUSH.
  - Function popcount_keep.
  - Function keep_mask(n), which returns n low ones.
- Sub-module axis_keep_count: combinational popcount of in_tkeep; reused by the shifter.
- All other logic lives in one module.

Test Plan:
Bench configuration: BUS_WIDTH=32, S=2; bytes below are listed lane 0 first.
- 3 beats, bytes 00..0B, keep F/F/F, tlast on beat 3 -> out {02,03,04,05} keep F; {06,07,08,09} keep F; {0A,0B} keep 3 tlast. The FLUSH cycle shows in_tready=0.
- 2 beats, bytes 00..03 keep F, then 04,05 keep 3 tlast -> single out {02,03,04,05} keep F tlast. No flush.
- Single beat 00..03 keep F tlast -> {02,03} keep 3 tlast, one cycle later. runt_err stays 0.
- Single beat keep 3 tlast -> no out_tvalid; runt_err high exactly one cycle. With AXIS_UNSHIFT_HDR_EN: hdr_data=0x0100 and hdr_valid pulses.
- 100 random packets (1-64 bytes) with out_tready toggling at 50% -> output byte stream equals input minus 2 bytes per packet. Stalled out_* fields stay stable. Runt count matches.
- ARESET asserted after beat 2 of a 4-beat packet -> all outputs 0 asynchronously. The next packet's output is clean, with no residue from the old hold register.
